// File: rtl/hilo_unit_pkg.sv
// Shared opcodes and widths for the HI/LO unit and the EX stage that drives it.
package hilo_unit_pkg;

  localparam int HILO_OP_W = 3;
  localparam int CNT_W     = 6;

  // ALU control codes the unit reacts to; must track the core's ALU decode table.
  localparam logic [4:0] ALU_MULT = 5'd10;
  localparam logic [4:0] ALU_DIV  = 5'd11;

  typedef enum logic [HILO_OP_W-1:0] {
    HILO_NONE = 3'd0,
    HILO_MFHI = 3'd1,
    HILO_MFLO = 3'd2,
    HILO_MTHI = 3'd3,
    HILO_MTLO = 3'd4
  } hilo_op_e;

endpackage

// File: rtl/hilo_unit_if.sv
// EX-stage to HI/LO unit bundle: request side from EX, status/read data back.
interface hilo_unit_if;
  import hilo_unit_pkg::*;

  logic                 ex_valid;
  logic [4:0]           sig_alu_control;
  logic [HILO_OP_W-1:0] sig_hilo_op;
  logic [31:0]          src_a;
  logic [31:0]          src_b;
  logic [31:0]          alu_hi;
  logic [31:0]          alu_lo;
  logic [31:0]          hilo_rdata;
  logic                 stall;
  logic                 busy;
  logic                 div_zero;

  modport master (
    output ex_valid, sig_alu_control, sig_hilo_op, src_a, src_b, alu_hi, alu_lo,
    input  hilo_rdata, stall, busy, div_zero
  );

  modport slave (
    input  ex_valid, sig_alu_control, sig_hilo_op, src_a, src_b, alu_hi, alu_lo,
    output hilo_rdata, stall, busy, div_zero
  );

endinterface

// File: rtl/hilo_unit_latency_counter.sv
// Down-counter modelling mult/div latency; done_o marks the edge where it reaches zero.
module hilo_latency_counter
  import hilo_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: captures mult/div results, holds them for a fixed latency,
// then commits; serves mfhi/mflo/mthi/mtlo and stalls EX while a result is in flight.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hilo_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_LATENCY);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        div_zero_q, div_zero_d;
  logic        busy, commit;
  logic        is_mult, is_div, is_md, is_hop, accept_md, accept_hop, div_by_zero;

  assign is_mult     = bus.ex_valid && (bus.sig_alu_control == ALU_MULT);
  assign is_div      = bus.ex_valid && (bus.sig_alu_control == ALU_DIV);
  assign is_md       = is_mult || is_div;
  assign is_hop      = bus.ex_valid && (bus.sig_hilo_op != HILO_NONE);
  // A hilo op decoded alongside mult/div is dropped; mult/div takes priority.
  assign accept_md   = is_md && !busy;
  assign accept_hop  = is_hop && !is_md && !busy;
  assign div_by_zero = is_div && (bus.src_b == 32'h0);

  hilo_latency_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept_md),
    .load_val_i (is_div ? DIV_LAT : MULT_LAT),
    .busy_o     (busy),
    .done_o     (commit)
  );

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    div_zero_d = 1'b0;
    if (commit) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end
    if (accept_hop && bus.sig_hilo_op == HILO_MTHI) hi_d = bus.src_a;
    if (accept_hop && bus.sig_hilo_op == HILO_MTLO) lo_d = bus.src_a;
    if (accept_md) begin
      if (div_by_zero) begin
        pend_hi_d  = bus.src_a;
        pend_lo_d  = 32'hFFFF_FFFF;
        div_zero_d = 1'b1;
      end else begin
        pend_hi_d  = bus.alu_hi;
        pend_lo_d  = bus.alu_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    bus.hilo_rdata = 32'h0;
    if (accept_hop && bus.sig_hilo_op == HILO_MFHI) bus.hilo_rdata = hi_q;
    if (accept_hop && bus.sig_hilo_op == HILO_MFLO) bus.hilo_rdata = lo_q;
  end

  assign bus.stall    = busy && (is_md || is_hop);
  assign bus.busy     = busy;
  assign bus.div_zero = div_zero_q;

endmodule
